// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin sharing of one APB master command port among NUM_REQ requesters
module apb_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDRESS = 8,
  parameter int DATA    = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                         PCLK,
  input  logic                         PRESET,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           req_rw,
  input  logic [NUM_REQ*ADDRESS-1:0]   req_addr,
  input  logic [NUM_REQ*DATA-1:0]      req_wdata,
  output logic [NUM_REQ-1:0]           ack,
  output logic                         err,
  output logic [DATA-1:0]              rdata,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy,
  output logic                         transfer,
  output logic                         READ_WRITE,
  output logic [ADDRESS-1:0]           apb_write_paddr,
  output logic [ADDRESS-1:0]           apb_read_paddr,
  output logic [DATA-1:0]              apb_write_data,
  input  logic [DATA-1:0]              apb_read_data_out,
  input  logic                         xfer_done
);
  localparam int LW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t              state_q;
  logic [LW-1:0]       ptr_q, grant_q, win_d;
  logic [CW-1:0]       cnt_q;
  logic                rw_q, err_q;
  logic [NUM_REQ-1:0]  ack_q;
  logic [ADDRESS-1:0]  waddr_q, raddr_q;
  logic [DATA-1:0]     wdata_q, rdata_q;
  // first set request at or above the pointer, wrapping; lower offsets overwrite higher ones
  always_comb begin
    win_d = ptr_q;
    for (int i = NUM_REQ-1; i >= 0; i--)
      if (req[ptr_q + LW'(i)]) win_d = ptr_q + LW'(i);
  end
  // arbitration FSM with registered command, ack and error outputs
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      err_q   <= 1'b0;
      ack_q   <= '0;
      waddr_q <= '0;
      raddr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      ack_q <= '0;
      err_q <= 1'b0;
      if (state_q == IDLE) begin
        if (|req) begin
          grant_q <= win_d;
          rw_q    <= req_rw[win_d];
          if (req_rw[win_d]) begin
            waddr_q <= req_addr[int'(win_d)*ADDRESS +: ADDRESS];
            wdata_q <= req_wdata[int'(win_d)*DATA +: DATA];
          end else
            raddr_q <= req_addr[int'(win_d)*ADDRESS +: ADDRESS];
          cnt_q   <= '0;
          state_q <= BUSY;
        end
      end else if (xfer_done || cnt_q == CW'(TIMEOUT-1)) begin
        if (xfer_done && !rw_q) rdata_q <= apb_read_data_out;
        ack_q[grant_q] <= 1'b1;
        err_q   <= !xfer_done;
        ptr_q   <= grant_q + 1'b1;
        state_q <= IDLE;
      end else
        cnt_q <= cnt_q + 1'b1;
    end
  end
  assign transfer        = (state_q == BUSY);
  assign busy            = (state_q == BUSY);
  assign ack             = ack_q;
  assign err             = err_q;
  assign rdata           = rdata_q;
  assign grant_id        = grant_q;
  assign READ_WRITE      = rw_q;
  assign apb_write_paddr = waddr_q;
  assign apb_read_paddr  = raddr_q;
  assign apb_write_data  = wdata_q;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: directed and randomized transactions checked against a transaction-level model
module tb_apb_req_arbiter;
  localparam int N = 4, AW = 8, DW = 8, TO = 16;
  logic              PCLK = 1'b0, PRESET;
  logic [N-1:0]      req, req_rw, ack;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic              err, busy, transfer, READ_WRITE, xfer_done;
  logic [DW-1:0]     rdata, apb_write_data, apb_read_data_out;
  logic [1:0]        grant_id;
  logic [AW-1:0]     apb_write_paddr, apb_read_paddr;
  int                total = 0, bad = 0, ptr = 0, e_grant = 0;
  logic [AW-1:0]     e_waddr, e_raddr;
  logic [DW-1:0]     e_wdata, e_rdata;
  apb_req_arbiter #(.NUM_REQ(N), .ADDRESS(AW), .DATA(DW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack(ack), .err(err), .rdata(rdata), .grant_id(grant_id),
    .busy(busy), .transfer(transfer), .READ_WRITE(READ_WRITE),
    .apb_write_paddr(apb_write_paddr), .apb_read_paddr(apb_read_paddr),
    .apb_write_data(apb_write_data), .apb_read_data_out(apb_read_data_out),
    .xfer_done(xfer_done)
  );
  always #5 PCLK = ~PCLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int winner(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p+k)%N]) return (p+k)%N;
    return -1;
  endfunction
  task automatic cycle;
    @(posedge PCLK);
    #1;
  endtask
  task automatic post(input int i, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] w);
    req[i] = 1'b1;
    req_rw[i] = rw;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = w;
  endtask
  task automatic model_reset;
    ptr = 0; e_grant = 0; e_waddr = '0; e_raddr = '0; e_wdata = '0; e_rdata = '0;
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_transfer"}, transfer, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_grant"}, grant_id, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_cmd"}, {READ_WRITE, apb_write_paddr, apb_read_paddr, apb_write_data}, 0);
  endtask
  task automatic do_reset;
    PRESET = 1'b1; req = '0; xfer_done = 1'b0;
    #1;
    check_zero("reset");
    cycle;
    PRESET = 1'b0;
    model_reset();
  endtask
  // one granted transaction; d = BUSY cycle carrying xfer_done (1..TO), 0 = never
  task automatic do_xfer(input int d, input logic [DW-1:0] rd, input bit drop_early);
    int g;
    logic rw;
    g = winner(req, ptr);
    rw = req_rw[g];
    if (rw) begin
      e_waddr = req_addr[g*AW +: AW];
      e_wdata = req_wdata[g*DW +: DW];
    end else e_raddr = req_addr[g*AW +: AW];
    cycle;
    chk("xfer_rise", transfer, 1);
    chk("busy_rise", busy, 1);
    chk("grant", grant_id, g);
    chk("rw", READ_WRITE, rw);
    chk("waddr", apb_write_paddr, e_waddr);
    chk("wdata", apb_write_data, e_wdata);
    chk("raddr", apb_read_paddr, e_raddr);
    req_rw[g] = ~rw;
    req_addr[g*AW +: AW] = AW'($urandom);
    req_wdata[g*DW +: DW] = DW'($urandom);
    if (drop_early) req[g] = 1'b0;
    for (int c = 1; c <= TO; c++) begin
      xfer_done = (c == d);
      apb_read_data_out = (c == d) ? rd : DW'($urandom);
      cycle;
      xfer_done = 1'b0;
      if (c == d || c == TO) break;
      chk("hold_xfer", transfer, 1);
      chk("hold_ack", ack, 0);
      chk("hold_cmd", {READ_WRITE, apb_write_paddr, apb_read_paddr, apb_write_data},
          {rw, e_waddr, e_raddr, e_wdata});
    end
    if (d != 0 && !rw) e_rdata = rd;
    chk("ack", ack, 1 << g);
    chk("err", err, d == 0);
    chk("rdata", rdata, e_rdata);
    chk("xfer_low", transfer, 0);
    chk("busy_low", busy, 0);
    chk("grant_hold", grant_id, g);
    req[g] = 1'b0;
    ptr = (g + 1) % N;
    e_grant = g;
  endtask
  initial begin
    req_rw = '0; req_addr = '0; req_wdata = '0; apb_read_data_out = '0;
    do_reset();
    post(0, 1'b1, 8'h02, 8'h06);
    do_xfer(2, 8'h00, 1'b0);
    post(2, 1'b0, 8'h0F, 8'h00);
    do_xfer(2, 8'h03, 1'b0);
    chk("read_grant", grant_id, 2);
    chk("read_rdata", rdata, 8'h03);
    xfer_done = 1'b1;
    cycle;
    xfer_done = 1'b0;
    chk("idle_done_xfer", transfer, 0);
    chk("idle_done_ack", ack, 0);
    chk("idle_done_rdata", rdata, 8'h03);
    do_reset();
    for (int i = 0; i < N; i++) post(i, i[0], AW'(8'h40 + i), DW'(8'h80 + i));
    for (int k = 0; k < N; k++) begin
      do_xfer(1 + k, DW'(8'h50 + k), 1'b0);
      chk("rr_order", grant_id, k);
    end
    post(0, 1'b0, 8'h33, 8'h00);
    do_xfer(3, 8'hA5, 1'b0);
    chk("rr_wrap", grant_id, 0);
    post(1, 1'b1, 8'h14, 8'h3F);
    post(2, 1'b0, 8'h21, 8'h00);
    do_xfer(0, 8'hEE, 1'b0);
    chk("timeout_err", err, 1);
    chk("timeout_rdata", rdata, 8'hA5);
    do_xfer(TO, 8'h7C, 1'b0);
    chk("last_cycle_grant", grant_id, 2);
    chk("last_cycle_err", err, 0);
    post(1, 1'b1, 8'h55, 8'h66);
    cycle;
    cycle;
    #2;
    PRESET = 1'b1;
    #1;
    check_zero("mid_reset");
    req = '0;
    post(3, 1'b0, 8'h99, 8'h00);
    cycle;
    PRESET = 1'b0;
    model_reset();
    do_xfer(4, 8'h12, 1'b0);
    chk("post_reset_grant", grant_id, 3);
    for (int t = 0; t < 150; t++) begin
      int d;
      for (int i = 0; i < N; i++)
        if (!req[i] && $urandom_range(0, 2) == 0)
          post(i, 1'($urandom), AW'($urandom), DW'($urandom));
      if (req == '0) post($urandom_range(0, N-1), 1'($urandom), AW'($urandom), DW'($urandom));
      d = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) == 1 ? 0 : TO) : $urandom_range(1, TO-1);
      do_xfer(d, DW'($urandom), 1'($urandom_range(0, 3) == 0));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
